// File: rtl/keystroke_buffer_if.sv
// Byte-stream and letter-FIFO signal bundle for keystroke_buffer.
// slave is the buffer's view; master is the view of whatever drives it.
interface keystroke_buffer_if #(
    parameter int ADDR_W = 2
) ();
    logic [7:0]      scan_code;
    logic            scan_ready;
    logic            read;
    logic            letter_valid;
    logic [4:0]      letter_code;
    logic [25:0]     letter_onehot;
    logic            letter_accept;
    logic [ADDR_W:0] fifo_count;
    logic            overflow;

    modport master (
        output scan_code, scan_ready, letter_accept,
        input  read, letter_valid, letter_code, letter_onehot, fifo_count, overflow
    );

    modport slave (
        input  scan_code, scan_ready, letter_accept,
        output read, letter_valid, letter_code, letter_onehot, fifo_count, overflow
    );
endinterface

// File: rtl/keystroke_buffer.sv
// PS/2 Set-2 byte parser with typematic suppression feeding a small letter FIFO.
// Each accepted letter leaves through a valid/accept handshake, head-first.
module keystroke_buffer #(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 2,
    parameter bit SUPPRESS_REP = 1'b1
) (
    input logic               clock,
    input logic               reset,
    keystroke_buffer_if.slave bus
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BREAK     = 2'd1;
    localparam logic [1:0] ST_EXT       = 2'd2;
    localparam logic [1:0] ST_EXT_BREAK = 2'd3;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    // Returns {is_letter, letter index 0=A..25=Z}.
    function automatic logic [5:0] decode(input logic [7:0] code);
        case (code)
            8'h1C: decode = {1'b1, 5'd0};
            8'h32: decode = {1'b1, 5'd1};
            8'h21: decode = {1'b1, 5'd2};
            8'h23: decode = {1'b1, 5'd3};
            8'h24: decode = {1'b1, 5'd4};
            8'h2B: decode = {1'b1, 5'd5};
            8'h34: decode = {1'b1, 5'd6};
            8'h33: decode = {1'b1, 5'd7};
            8'h43: decode = {1'b1, 5'd8};
            8'h3B: decode = {1'b1, 5'd9};
            8'h42: decode = {1'b1, 5'd10};
            8'h4B: decode = {1'b1, 5'd11};
            8'h3A: decode = {1'b1, 5'd12};
            8'h31: decode = {1'b1, 5'd13};
            8'h44: decode = {1'b1, 5'd14};
            8'h4D: decode = {1'b1, 5'd15};
            8'h15: decode = {1'b1, 5'd16};
            8'h2D: decode = {1'b1, 5'd17};
            8'h1B: decode = {1'b1, 5'd18};
            8'h2C: decode = {1'b1, 5'd19};
            8'h3C: decode = {1'b1, 5'd20};
            8'h2A: decode = {1'b1, 5'd21};
            8'h1D: decode = {1'b1, 5'd22};
            8'h22: decode = {1'b1, 5'd23};
            8'h35: decode = {1'b1, 5'd24};
            8'h1A: decode = {1'b1, 5'd25};
            default: decode = 6'd0;
        endcase
    endfunction

    logic              sr_q;
    logic              read_q;
    logic [1:0]        state;
    logic [7:0]        held_code;
    logic              held_valid;
    logic [4:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow_q;

    logic       is_letter;
    logic [4:0] letter_idx;
    logic       ev;
    logic       repeat_hit;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       valid;
    logic       full;

    assign {is_letter, letter_idx} = decode(bus.scan_code);

    assign ev         = bus.scan_ready & ~sr_q;
    assign repeat_hit = SUPPRESS_REP & held_valid & (bus.scan_code == held_code);
    assign push_req   = ev & (state == ST_IDLE) & is_letter & ~repeat_hit;
    assign valid      = (count != '0);
    assign full       = (count == FULL_COUNT);
    assign pop        = valid & bus.letter_accept;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok    = push_req & (~full | pop);

    always_ff @(posedge clock) begin
        // NOTE: sr_q follows scan_ready even during reset, so a byte still pending at reset exit is not taken as new.
        sr_q <= bus.scan_ready;
        if (reset) begin
            read_q     <= 1'b0;
            state      <= ST_IDLE;
            held_code  <= 8'h00;
            held_valid <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            read_q <= ev;

            if (ev) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.scan_code == CODE_BREAK)
                            state <= ST_BREAK;
                        else if (bus.scan_code == CODE_EXT)
                            state <= ST_EXT;
                    end
                    ST_BREAK: begin
                        state <= ST_IDLE;
                        if (bus.scan_code == held_code)
                            held_valid <= 1'b0;
                    end
                    ST_EXT:
                        state <= (bus.scan_code == CODE_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                    default:
                        state <= ST_IDLE;
                endcase
            end

            // The held key tracks every pushed letter, including one dropped on overflow.
            if (push_req) begin
                held_code  <= bus.scan_code;
                held_valid <= 1'b1;
            end

            if (push_req & ~push_ok)
                overflow_q <= 1'b1;

            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;

            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; only the pointers and count define which entries are live.
        if (!reset && push_ok)
            mem[wr_ptr] <= letter_idx;
    end

    assign bus.read          = read_q;
    assign bus.letter_valid  = valid;
    assign bus.letter_code   = valid ? mem[rd_ptr] : 5'd0;
    assign bus.letter_onehot = valid ? (26'(1) << bus.letter_code) : 26'd0;
    assign bus.fifo_count    = count;
    assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_keystroke_buffer.sv
// Bench for keystroke_buffer: two instances (repeat suppression off/on) share one byte stream
// and are compared every cycle against a queue-level model, plus directed sequences.
module tb_keystroke_buffer;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       letter_accept;

    always #5 clock = ~clock;

    keystroke_buffer_if #(.ADDR_W(2)) b0 ();
    keystroke_buffer_if #(.ADDR_W(2)) b1 ();

    assign b0.scan_code     = scan_code;
    assign b0.scan_ready    = scan_ready;
    assign b0.letter_accept = letter_accept;
    assign b1.scan_code     = scan_code;
    assign b1.scan_ready    = scan_ready;
    assign b1.letter_accept = letter_accept;

    keystroke_buffer #(.DEPTH(4), .ADDR_W(2), .SUPPRESS_REP(1'b0)) dut0 (
        .clock(clock), .reset(reset), .bus(b0)
    );
    keystroke_buffer #(.DEPTH(4), .ADDR_W(2), .SUPPRESS_REP(1'b1)) dut1 (
        .clock(clock), .reset(reset), .bus(b1)
    );

    typedef struct {
        logic [7:0] code;
        bit         is_letter;
        logic [4:0] idx;
    } vec_t;

    vec_t vtab [30];

    int total = 0;
    int bad   = 0;
    int n_reads;
    int n_a_cycles;

    // Reference model; index 0 = no repeat suppression, 1 = suppression.
    bit         m_sr;
    bit         m_read;
    int         m_fifo [2][4];
    int         m_n    [2];
    bit         m_ovf  [2];
    bit         m_hv   [2];
    logic [7:0] m_hc   [2];
    bit         m_brk  [2];
    bit         m_ext  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int letter_of(input logic [7:0] c);
        for (int i = 0; i < 30; i++)
            if (vtab[i].is_letter && vtab[i].code == c) return int'(vtab[i].idx);
        return -1;
    endfunction

    task automatic model_byte(input int k, input logic [7:0] c);
        int li;
        li = letter_of(c);
        if (!m_brk[k] && !m_ext[k]) begin
            if (c == 8'hF0) m_brk[k] = 1'b1;
            else if (c == 8'hE0) m_ext[k] = 1'b1;
            else if (li >= 0) begin
                if (!(k == 1 && m_hv[k] && c == m_hc[k])) begin
                    if (m_n[k] < 4) begin
                        m_fifo[k][m_n[k]] = li;
                        m_n[k]++;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                    m_hc[k] = c;
                    m_hv[k] = 1'b1;
                end
            end
        end else if (m_brk[k] && !m_ext[k]) begin
            m_brk[k] = 1'b0;
            if (c == m_hc[k]) m_hv[k] = 1'b0;
        end else if (m_ext[k] && !m_brk[k]) begin
            if (c == 8'hF0) m_brk[k] = 1'b1;
            else m_ext[k] = 1'b0;
        end else begin
            m_brk[k] = 1'b0;
            m_ext[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit ev;
        if (reset) begin
            m_read = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_n[k] = 0; m_ovf[k] = 1'b0; m_hv[k] = 1'b0;
                m_hc[k] = 8'h00; m_brk[k] = 1'b0; m_ext[k] = 1'b0;
            end
        end else begin
            ev = scan_ready && !m_sr;
            for (int k = 0; k < 2; k++) begin
                if (m_n[k] > 0 && letter_accept) begin
                    for (int j = 0; j < 3; j++) m_fifo[k][j] = m_fifo[k][j+1];
                    m_n[k]--;
                end
                if (ev) model_byte(k, scan_code);
            end
            m_read = ev;
        end
        m_sr = scan_ready;
    endtask

    task automatic cmp(input string tag, input int k, input logic v, input logic [4:0] c,
                       input logic [25:0] oh, input logic [2:0] n, input logic o, input logic r);
        int ec;
        ec = (m_n[k] > 0) ? m_fifo[k][0] : 0;
        chk({tag, ".valid"}, 32'(v), 32'(m_n[k] > 0));
        chk({tag, ".code"}, 32'(c), 32'(ec));
        chk({tag, ".onehot"}, 32'(oh), (m_n[k] > 0) ? (32'd1 << ec) : 32'd0);
        chk({tag, ".count"}, 32'(n), 32'(m_n[k]));
        chk({tag, ".overflow"}, 32'(o), 32'(m_ovf[k]));
        chk({tag, ".read"}, 32'(r), 32'(m_read));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        cmp("s0", 0, b0.letter_valid, b0.letter_code, b0.letter_onehot, b0.fifo_count, b0.overflow, b0.read);
        cmp("s1", 1, b1.letter_valid, b1.letter_code, b1.letter_onehot, b1.fifo_count, b1.overflow, b1.read);
        if (b1.read) n_reads++;
        if (b1.letter_valid && b1.letter_onehot == 26'h1) n_a_cycles++;
    endtask

    task automatic send(input logic [7:0] c);
        scan_code  = c;
        scan_ready = 1'b1;
        tick();
        scan_ready = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [4:0] drain_exp [4];

    initial begin
        vtab[0]  = '{8'h1C, 1'b1, 5'd0};   vtab[1]  = '{8'h32, 1'b1, 5'd1};
        vtab[2]  = '{8'h21, 1'b1, 5'd2};   vtab[3]  = '{8'h23, 1'b1, 5'd3};
        vtab[4]  = '{8'h24, 1'b1, 5'd4};   vtab[5]  = '{8'h2B, 1'b1, 5'd5};
        vtab[6]  = '{8'h34, 1'b1, 5'd6};   vtab[7]  = '{8'h33, 1'b1, 5'd7};
        vtab[8]  = '{8'h43, 1'b1, 5'd8};   vtab[9]  = '{8'h3B, 1'b1, 5'd9};
        vtab[10] = '{8'h42, 1'b1, 5'd10};  vtab[11] = '{8'h4B, 1'b1, 5'd11};
        vtab[12] = '{8'h3A, 1'b1, 5'd12};  vtab[13] = '{8'h31, 1'b1, 5'd13};
        vtab[14] = '{8'h44, 1'b1, 5'd14};  vtab[15] = '{8'h4D, 1'b1, 5'd15};
        vtab[16] = '{8'h15, 1'b1, 5'd16};  vtab[17] = '{8'h2D, 1'b1, 5'd17};
        vtab[18] = '{8'h1B, 1'b1, 5'd18};  vtab[19] = '{8'h2C, 1'b1, 5'd19};
        vtab[20] = '{8'h3C, 1'b1, 5'd20};  vtab[21] = '{8'h2A, 1'b1, 5'd21};
        vtab[22] = '{8'h1D, 1'b1, 5'd22};  vtab[23] = '{8'h22, 1'b1, 5'd23};
        vtab[24] = '{8'h35, 1'b1, 5'd24};  vtab[25] = '{8'h1A, 1'b1, 5'd25};
        vtab[26] = '{8'h1E, 1'b0, 5'd0};   vtab[27] = '{8'h29, 1'b0, 5'd0};
        vtab[28] = '{8'h00, 1'b0, 5'd0};   vtab[29] = '{8'hFF, 1'b0, 5'd0};

        reset = 1'b1; scan_code = 8'h00; scan_ready = 1'b0; letter_accept = 1'b0;
        n_reads = 0; n_a_cycles = 0;
        tick();
        reset = 1'b0;
        chk("reset.valid", 32'(b1.letter_valid), 32'd0);
        chk("reset.count", 32'(b1.fifo_count), 32'd0);
        chk("reset.onehot", 32'(b1.letter_onehot), 32'd0);

        // Letter map table
        for (int i = 0; i < 30; i++) begin
            letter_accept = 1'b0;
            send(vtab[i].code);
            chk($sformatf("map%0d.valid", i), 32'(b1.letter_valid), 32'(vtab[i].is_letter));
            chk($sformatf("map%0d.code", i), 32'(b1.letter_code),
                vtab[i].is_letter ? 32'(vtab[i].idx) : 32'd0);
            chk($sformatf("map%0d.onehot", i), 32'(b1.letter_onehot),
                vtab[i].is_letter ? (32'd1 << vtab[i].idx) : 32'd0);
            letter_accept = 1'b1;
            tick();
            letter_accept = 1'b0;
        end

        // Make/break of A with accept held high
        pulse_reset();
        n_reads = 0; n_a_cycles = 0;
        letter_accept = 1'b1;
        send(8'h1C); send(8'hF0); send(8'h1C);
        tick(); tick();
        chk("t1.reads", 32'(n_reads), 32'd3);
        chk("t1.a_cycles", 32'(n_a_cycles), 32'd1);

        // Typematic repeats of R
        pulse_reset();
        letter_accept = 1'b0;
        send(8'h2D); send(8'h2D); send(8'h2D); send(8'hF0); send(8'h2D); send(8'h2D);
        chk("t2.sup_count", 32'(b1.fifo_count), 32'd2);
        chk("t2.sup_head", 32'(b1.letter_code), 32'd17);
        chk("t2.nosup_count", 32'(b0.fifo_count), 32'd4);

        // Extended keys never produce letters
        pulse_reset();
        send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C); send(8'h13);
        chk("t3.valid", 32'(b1.letter_valid), 32'd0);
        send(8'h1C);
        chk("t3.idle_after", 32'(b1.fifo_count), 32'd1);

        // Overflow then ordered drain
        pulse_reset();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        chk("t4.count", 32'(b1.fifo_count), 32'd4);
        chk("t4.overflow", 32'(b1.overflow), 32'd1);
        letter_accept = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4.drain%0d", i), 32'(b1.letter_code), 32'(i));
            tick();
        end
        chk("t4.empty", 32'(b1.letter_valid), 32'd0);

        // Push and pop together while full
        pulse_reset();
        letter_accept = 1'b0;
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        letter_accept = 1'b1; scan_code = 8'h1A; scan_ready = 1'b1;
        tick();
        scan_ready = 1'b0;
        chk("t5.count", 32'(b1.fifo_count), 32'd4);
        chk("t5.overflow", 32'(b1.overflow), 32'd0);
        drain_exp[0] = 5'd1; drain_exp[1] = 5'd2; drain_exp[2] = 5'd3; drain_exp[3] = 5'd25;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5.drain%0d", i), 32'(b1.letter_code), 32'(drain_exp[i]));
            tick();
        end
        chk("t5.empty", 32'(b1.letter_valid), 32'd0);

        // Reset with a byte pending
        pulse_reset();
        letter_accept = 1'b0;
        send(8'h1C); send(8'h32);
        scan_code = 8'h21; scan_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6.count", 32'(b1.fifo_count), 32'd0);
        chk("t6.code", 32'(b1.letter_code), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("t6.no_push", 32'(b1.fifo_count), 32'd0);
        scan_ready = 1'b0; tick();
        scan_ready = 1'b1; tick();
        chk("t6.new_byte", 32'(b1.fifo_count), 32'd1);
        scan_ready = 1'b0; tick();

        // Random stream against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) scan_ready = ~scan_ready;
            case ($urandom_range(0, 5))
                0:       scan_code = 8'hF0;
                1:       scan_code = 8'hE0;
                2:       scan_code = 8'($urandom_range(0, 255));
                default: scan_code = vtab[$urandom_range(0, 4)].code;
            endcase
            letter_accept = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
